// File: rtl/apb_pkg.sv
// apb_pkg: shared types and helpers for the APB master bridge.
//   - apb_state_e : bridge FSM states
//   - SZ_*        : load/store size codes (funct3[1:0])
//   - gen_pstrb   : byte-lane strobes from size and address low bits
//   - gen_pwdata  : write-data lane replication from size
//   - is_aligned  : size/address alignment check (size 11 never aligned)
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} apb_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic [3:0] gen_pstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    gen_pstrb = 4'b0001 << addr_lo;
      SZ_H:    gen_pstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    gen_pstrb = 4'b1111;
      default: gen_pstrb = 4'b0000;
    endcase
  endfunction

  // Store data arrives right-aligned; replicating it across the lanes lets
  // the strobes alone pick the bytes the slave writes.
  function automatic logic [31:0] gen_pwdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_B:    gen_pwdata = {4{wdata[7:0]}};
      SZ_H:    gen_pwdata = {2{wdata[15:0]}};
      default: gen_pwdata = wdata;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    is_aligned = 1'b1;
      SZ_H:    is_aligned = ~addr_lo[0];
      SZ_W:    is_aligned = (addr_lo == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: combinational slave decode of the peripheral window.
//   addr_hi : address bits above the per-slave span
//   hit     : address lands on an existing slave
//   idx     : slave index field
//   sel     : one-hot slave select (all zero on a miss)
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV       = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
  parameter int          SLV_SPAN_LOG2 = 12,
  localparam int         IW            = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [31:SLV_SPAN_LOG2] addr_hi,
  output logic                    hit,
  output logic [IW-1:0]           idx,
  output logic [NUM_SLV-1:0]      sel
);

  logic tag_ok;

  assign idx    = addr_hi[SLV_SPAN_LOG2 +: IW];
  assign tag_ok = (addr_hi[31:SLV_SPAN_LOG2+IW] == BASE_ADDR[31:SLV_SPAN_LOG2+IW]);
  // Index codes past the last slave (non power-of-two NUM_SLV) are misses.
  assign hit    = tag_ok && (int'(idx) < NUM_SLV);

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_sel
    assign sel[i] = hit && (idx == IW'(i));
  end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB4 master bridging the CPU transfer/ready bus to
// NUM_SLV slaves.
//   CPU side : transfer, busWe, busAddr, strb (funct3), busWData in;
//              busRData, ready (1-cycle pulse), busErr out.
//   APB side : PADDR, PWRITE, PWDATA, PSTRB, PSEL (one-hot), PENABLE out;
//              PRDATA (flattened, slave i at [32i+:32]), PREADY, PSLVERR in.
// Decode misses, misalignment, PSLVERR and PREADY timeouts all complete with
// ready=1 and busErr=1.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          NUM_SLV       = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
  parameter int          SLV_SPAN_LOG2 = 12,
  parameter int          TIMEOUT       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  transfer,
  input  logic                  busWe,
  input  logic [31:0]           busAddr,
  input  logic [2:0]            strb,
  input  logic [31:0]           busWData,
  output logic [31:0]           busRData,
  output logic                  ready,
  output logic                  busErr,
  output logic [31:0]           PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  output logic [NUM_SLV-1:0]    PSEL,
  output logic                  PENABLE,
  input  logic [NUM_SLV*32-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY,
  input  logic [NUM_SLV-1:0]    PSLVERR
);

  localparam int          IW      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int          CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e         state;
  logic [CW-1:0]      cnt;
  logic               dec_hit;
  logic [IW-1:0]      unused_idx;
  logic [NUM_SLV-1:0] dec_sel;
  logic               unused_sign;
  logic [31:0]        rd_mux;
  logic               rdy_sel, err_sel, tmo, done;

  // Sign bit of funct3 only matters to the CPU's load extension.
  assign unused_sign = strb[2];

  apb_addr_decoder #(
    .NUM_SLV      (NUM_SLV),
    .BASE_ADDR    (BASE_ADDR),
    .SLV_SPAN_LOG2(SLV_SPAN_LOG2)
  ) u_dec (
    .addr_hi(busAddr[31:SLV_SPAN_LOG2]),
    .hit    (dec_hit),
    .idx    (unused_idx),
    .sel    (dec_sel)
  );

  // PSEL is held through ACCESS, so it doubles as the response mux select.
  always_comb begin
    rd_mux  = '0;
    rdy_sel = 1'b0;
    err_sel = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (PSEL[i]) begin
        rd_mux  = rd_mux | PRDATA[32*i +: 32];
        rdy_sel = rdy_sel | PREADY[i];
        err_sel = err_sel | PSLVERR[i];
      end
    end
  end

  assign tmo  = (TIMEOUT > 0) && (state == ACCESS) && !rdy_sel && (cnt == TO_LAST);
  assign done = (state == ACCESS) && (rdy_sel || tmo);

  // Completion is reported in the same cycle PREADY is seen.
  always_comb begin
    ready    = 1'b0;
    busErr   = 1'b0;
    busRData = '0;
    if (state == ERR) begin
      ready  = 1'b1;
      busErr = 1'b1;
    end else if (done) begin
      ready  = 1'b1;
      busErr = tmo ? 1'b1 : err_sel;
      if (rdy_sel && !PWRITE) busRData = rd_mux;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTRB   <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
    end else begin
      case (state)
        IDLE: if (transfer) begin
          PADDR  <= busAddr;
          PWRITE <= busWe;
          PSTRB  <= busWe ? gen_pstrb(strb[1:0], busAddr[1:0]) : 4'b0000;
          PWDATA <= busWe ? gen_pwdata(strb[1:0], busWData) : 32'h0;
          cnt    <= '0;
          if (dec_hit && is_aligned(strb[1:0], busAddr[1:0])) begin
            PSEL  <= dec_sel;
            state <= SETUP;
          end else begin
            state <= ERR;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small wait-state slave model.
module tb_apb_master_bridge;

  logic         clk, reset, transfer, busWe, ready, busErr, PWRITE, PENABLE;
  logic [31:0]  busAddr, busWData, busRData, PADDR, PWDATA;
  logic [2:0]   strb;
  logic [3:0]   PSTRB, PSEL, PREADY, PSLVERR;
  logic [127:0] PRDATA;

  int total = 0;
  int bad   = 0;
  int ws[4];
  int acc_cnt;

  // Results of the last transfer
  logic [31:0] r_lat, r_err, r_rdata, r_pselv, r_psel_n, r_pen_n, r_pstrb, r_pwdata, r_after;

  apb_master_bridge #(
    .NUM_SLV(4), .BASE_ADDR(32'h1000_0000), .SLV_SPAN_LOG2(12), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .transfer(transfer), .busWe(busWe),
    .busAddr(busAddr), .strb(strb), .busWData(busWData),
    .busRData(busRData), .ready(ready), .busErr(busErr),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: slave i answers after ws[i] ACCESS wait cycles.
  always @(posedge clk) begin
    if (PENABLE && !ready) acc_cnt <= acc_cnt + 1;
    else                   acc_cnt <= 0;
  end

  always_comb begin
    PREADY = '0;
    for (int i = 0; i < 4; i++)
      PREADY[i] = PSEL[i] & PENABLE & (acc_cnt >= ws[i]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge and watch it to completion; returns at
  // the negedge one cycle after ready.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wd);
    logic fin;
    fin = 1'b0;
    r_lat = 0; r_err = 0; r_rdata = 0; r_pselv = 0; r_psel_n = 0; r_pen_n = 0;
    r_pstrb = 0; r_pwdata = 0;
    busWe = we; busAddr = addr; strb = sz; busWData = wd; transfer = 1'b1;
    while (!fin && r_lat < 40) begin
      @(posedge clk); @(negedge clk);
      r_lat++;
      if (PSEL != 0) begin
        r_psel_n++;
        r_pselv  = 32'(PSEL);
        r_pstrb  = 32'(PSTRB);
        r_pwdata = PWDATA;
      end
      if (PENABLE) r_pen_n++;
      if (ready) begin
        fin     = 1'b1;
        r_err   = 32'(busErr);
        r_rdata = busRData;
      end
    end
    transfer = 1'b0;
    chk("xfer_done", 32'(fin), 1);
    @(posedge clk); @(negedge clk);
    r_after = {26'd0, ready, PENABLE, PSEL};
  endtask

  initial begin
    reset = 1'b0; transfer = 1'b0; busWe = 1'b0; busAddr = '0; strb = '0; busWData = '0;
    PSLVERR = '0;
    PRDATA = {32'h1234_5678, 32'h2222_3333, 32'h1111_2222, 32'hA0A0_0000};
    for (int i = 0; i < 4; i++) ws[i] = 0;

    #12;
    chk("rst_psel",  {27'd0, PENABLE, PSEL}, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_ready", {29'd0, ready, busErr, PWRITE}, 0);
    chk("rst_rdata", busRData, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // Word write to slave 1, zero wait states
    xfer(1'b1, 32'h1000_1004, 3'b010, 32'hDEAD_BEEF);
    chk("w_psel",    r_pselv, 32'h2);
    chk("w_psel_n",  r_psel_n, 2);
    chk("w_pen_n",   r_pen_n, 1);
    chk("w_pstrb",   r_pstrb, 32'hF);
    chk("w_pwdata",  r_pwdata, 32'hDEAD_BEEF);
    chk("w_lat",     r_lat, 2);
    chk("w_err",     r_err, 0);
    chk("w_rdata",   r_rdata, 0);
    chk("w_after",   r_after, 0);

    // Byte write to top lane of slave 2
    xfer(1'b1, 32'h1000_2003, 3'b000, 32'h0000_00A5);
    chk("b_psel",   r_pselv, 32'h4);
    chk("b_pstrb",  r_pstrb, 32'h8);
    chk("b_pwdata", r_pwdata, 32'hA5A5_A5A5);
    chk("b_err",    r_err, 0);

    // Half write to upper half of slave 1
    xfer(1'b1, 32'h1000_1002, 3'b001, 32'h0000_BEEF);
    chk("h_pstrb",  r_pstrb, 32'hC);
    chk("h_pwdata", r_pwdata, 32'hBEEF_BEEF);

    // Read from slave 3 with four wait states
    ws[3] = 4;
    xfer(1'b0, 32'h1000_3000, 3'b010, 32'hFFFF_FFFF);
    chk("r_pen_n", r_pen_n, 5);
    chk("r_lat",   r_lat, 6);
    chk("r_rdata", r_rdata, 32'h1234_5678);
    chk("r_pstrb", r_pstrb, 0);
    chk("r_pwdata", r_pwdata, 0);
    chk("r_err",   r_err, 0);
    chk("r_after", r_after, 0);
    ws[3] = 0;

    // Decode miss
    xfer(1'b0, 32'h2000_0000, 3'b010, 32'h0);
    chk("miss_lat",   r_lat, 1);
    chk("miss_err",   r_err, 1);
    chk("miss_psel",  r_psel_n, 0);
    chk("miss_rdata", r_rdata, 0);
    chk("miss_after", r_after, 0);

    // Misaligned half write
    xfer(1'b1, 32'h1000_0001, 3'b001, 32'h1234);
    chk("mis_lat",  r_lat, 1);
    chk("mis_err",  r_err, 1);
    chk("mis_psel", r_psel_n, 0);

    // Reserved size code
    xfer(1'b0, 32'h1000_0000, 3'b011, 32'h0);
    chk("sz3_err",  r_err, 1);
    chk("sz3_psel", r_psel_n, 0);

    // Timeout: slave 0 never answers
    ws[0] = 1000;
    xfer(1'b0, 32'h1000_0010, 3'b010, 32'h0);
    chk("to_lat",   r_lat, 17);
    chk("to_pen_n", r_pen_n, 16);
    chk("to_err",   r_err, 1);
    chk("to_rdata", r_rdata, 0);
    chk("to_after", r_after, 0);
    ws[0] = 0;

    // Slave error on slave 2
    PSLVERR = 4'b0100;
    xfer(1'b0, 32'h1000_2008, 3'b010, 32'h0);
    chk("se_err",   r_err, 1);
    chk("se_rdata", r_rdata, 32'h2222_3333);
    chk("se_lat",   r_lat, 2);
    PSLVERR = '0;

    // Reset during ACCESS
    ws[1] = 1000;
    busWe = 1'b0; busAddr = 32'h1000_1000; strb = 3'b010; transfer = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("mid_pen", {27'd0, PENABLE, PSEL}, 32'h12);
    #2 reset = 1'b0;
    transfer = 1'b0;
    #1;
    chk("mid_clr", {26'd0, ready, PENABLE, PSEL}, 0);
    @(negedge clk);
    chk("mid_noready", 32'(ready), 0);
    reset = 1'b1;
    ws[1] = 0;
    @(negedge clk);
    xfer(1'b0, 32'h1000_1000, 3'b010, 32'h0);
    chk("post_lat",   r_lat, 2);
    chk("post_err",   r_err, 0);
    chk("post_rdata", r_rdata, 32'h1111_2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
